multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write enables, and produces the `ALUOp` code that the ALU decoder combines with the instruction funct bits. It sits between the instruction register (`op` field) and the datapath; it is the producing end of the `ALUOp` interface.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  single system clock; all state changes on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `op`  input  7  opcode, instr[6:0], from the instruction register
- `zero`  input  1  ALU zero flag
- `mem_ready`  input  1  memory handshake; 1 = the current access completes this cycle
- `ALUOp`  output  2  00 add, 01 subtract, 10 decode from funct
- `ALUSrcA`  output  2  00 PC, 01 OldPC, 10 register A
- `ALUSrcB`  output  2  00 register B, 01 ImmExt, 10 constant 4
- `ResultSrc`  output  2  00 ALUOut, 01 Data register, 10 ALUResult
- `ImmSrc`  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- `AdrSrc`  output  1  0 PC, 1 Result
- `IRWrite`  output  1  instruction register load enable
- `PCWrite`  output  1  PC load enable; equals `PCUpdate | (Branch & zero)`
- `RegWrite`  output  1  register file write enable
- `MemWrite`  output  1  data memory write request
- `illegal_op`  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- `state`  output  4  current state, for debug

## Operation
State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable; if ever entered, the next state is FETCH.

Outputs are a Moore decode of `state`, except where `mem_ready` or `zero` is named below. Any output not listed for a state is 0.

Per-state outputs and next state:
- **FETCH:** AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = mem_ready; PCUpdate = mem_ready.
  - Stay while mem_ready=0; otherwise go to DECODE.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state by `op`:
    - 0000011 (lw) or 0100011 (sw): MEMADR
    - 0110011: EXECR
    - 0010011: EXECI
    - 1100011: BEQ
    - 1101111: JAL
    - any other opcode: FETCH, with illegal_op=1 in this cycle
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Go to MEMREAD if op=lw; otherwise MEMWRITE.
- **MEMREAD:** AdrSrc=1, ResultSrc=00.
  - Stay while mem_ready=0; otherwise go to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1; then FETCH.
- **MEMWRITE:** AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite is held high until mem_ready=1; then FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, ALUOp=10; then ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10; then ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1; then FETCH.
- **BEQ:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - PCWrite = zero; then FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; then ALUWB.

ImmSrc is combinational from `op`, independent of state:
- lw or 0010011: 00
- sw: 01
- beq: 10
- jal: 11
- anything else: 00

## Timing
- **Reset:** rst=1 at a rising edge sets state=FETCH.
  - While rst=1, IRWrite, PCWrite, RegWrite, MemWrite and illegal_op are forced to 0.
  - The other outputs show FETCH values: ALUSrcB=10, ResultSrc=10, all other selects 00.
- **Reset mid-instruction:** returns to FETCH on the next edge. A pending MemWrite is dropped that cycle.
- **Cycle counts with mem_ready tied to 1:**
  - lw = 5 cycles
  - sw = 4
  - R-type and I-type ALU = 4
  - beq = 3
  - jal = 4
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- **Single-pulse rules:**
  - IRWrite and FETCH's PCWrite assert in exactly one cycle per instruction: the FETCH cycle with mem_ready=1.
  - RegWrite asserts in exactly one cycle per lw, ALU or jal instruction.
- **Timing of combinational inputs:** `zero` is sampled combinationally in BEQ; no registered branch decision. `op` must be stable from DECODE onward, which the IR guarantees because IRWrite=0 outside FETCH.

## Test plan
- **lw, no stalls:** reset, then op=0000011 with mem_ready=1 throughout.
  - Required: state sequence 0,1,2,3,4,0.
  - RegWrite=1 only in state 4; IRWrite=1 only in state 0; ImmSrc=00.
- **sw with stall:** op=0100011, mem_ready=0 for 2 cycles in MEMWRITE, then 1.
  - Required: MemWrite=1 for 3 consecutive cycles, then FETCH.
  - Total instruction length 6 cycles; ImmSrc=01.
- **beq taken and not taken:** op=1100011.
  - zero=1 in BEQ: PCWrite=1 and ALUOp=01.
  - zero=0 in BEQ: PCWrite=0.
  - Both cases: ImmSrc=10, 3 cycles, return to FETCH.
- **R-type and jal:**
  - op=0110011 gives ALUOp=10 and ALUSrcB=00 in EXECR, then RegWrite in ALUWB.
  - op=1101111 gives state sequence 0,1,10,8,0, with PCWrite=1 in JAL and ImmSrc=11.
- **Illegal opcode:** op=1111111 in DECODE.
  - Required: illegal_op=1 for exactly one cycle, next state FETCH, no RegWrite or MemWrite.
- **Reset mid-operation:** assert rst during MEMWRITE.
  - Required: MemWrite=0 that cycle, state=0 after the edge, and a clean lw sequence afterwards.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath: sequences fetch, decode,
// execute, memory and writeback, and drives datapath selects, enables and ALUOp.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_reg;
  state_t state_next;
  state_t dec_state;

  logic pc_update;
  logic branch;
  logic ir_write;
  logic reg_write;
  logic mem_write;
  logic illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // While in reset the selects show FETCH values even if the register still
  // holds a mid-instruction state.
  assign dec_state = rst ? FETCH : state_reg;

  always_comb begin
    state_next = FETCH;
    ALUOp      = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    case (dec_state)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  assign IRWrite    = ~rst & ir_write;
  assign PCWrite    = ~rst & (pc_update | (branch & zero));
  assign RegWrite   = ~rst & reg_write;
  assign MemWrite   = ~rst & mem_write;
  assign illegal_op = ~rst & illegal;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push hand-computed
// expected outputs; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int applied = 0;
  int miscompares = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Vector layout: state, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
  // IRWrite, PCWrite, RegWrite, MemWrite, illegal_op.
  wire [19:0] act = {state, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                     AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      applied++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got st=%0d aop=%b sa=%b sb=%b rs=%b imm=%b adr=%b ir=%b pcw=%b rw=%b mw=%b ill=%b, expected st=%0d aop=%b sa=%b sb=%b rs=%b imm=%b adr=%b ir=%b pcw=%b rw=%b mw=%b ill=%b",
                 it.name, act[19:16], act[15:14], act[13:12], act[11:10], act[9:8], act[7:6],
                 act[5], act[4], act[3], act[2], act[1], act[0],
                 it.exp[19:16], it.exp[15:14], it.exp[13:12], it.exp[11:10], it.exp[9:8], it.exp[7:6],
                 it.exp[5], it.exp[4], it.exp[3], it.exp[2], it.exp[1], it.exp[0]);
      end
    end
  end

  task automatic v(input string name, input logic r, input logic [6:0] o, input logic z,
                   input logic m, input logic [3:0] st, input logic [1:0] aop,
                   input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                   input logic [1:0] im, input logic ad, input logic ir, input logic pw,
                   input logic rw, input logic mw, input logic il);
    item_t it;
    rst = r; op = o; zero = z; mem_ready = m;
    it.exp  = {st, aop, sa, sb, rs, im, ad, ir, pw, rw, mw, il};
    it.name = name;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    //         name        rst op  z  m  st aop    sa     sb     rs     imm    ad ir pw rw mw il
    v("reset",           1, LW, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    // lw, no stalls
    v("lw_fetch",        0, LW, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
    v("lw_decode",       0, LW, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("lw_memadr",       0, LW, 0, 1, 2, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("lw_memread",      0, LW, 0, 1, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    v("lw_memwb",        0, LW, 0, 1, 4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0);
    // sw with two stall cycles in MEMWRITE
    v("sw_fetch",        0, SW, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 0, 1, 1, 0, 0, 0);
    v("sw_decode",       0, SW, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
    v("sw_memadr",       0, SW, 0, 1, 2, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
    v("sw_memwr_stall1", 0, SW, 0, 0, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 1, 0);
    v("sw_memwr_stall2", 0, SW, 0, 0, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 1, 0);
    v("sw_memwr_done",   0, SW, 0, 1, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 1, 0);
    // beq taken, with a FETCH stall first
    v("beq_fetch_stall", 0, BQ, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    v("beq_fetch",       0, BQ, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0);
    v("beq_decode",      0, BQ, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    v("beq_taken",       0, BQ, 1, 1, 9, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0);
    // beq not taken
    v("beqn_fetch",      0, BQ, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0);
    v("beqn_decode",     0, BQ, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    v("beq_not_taken",   0, BQ, 0, 1, 9, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    // R-type
    v("r_fetch",         0, RT, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
    v("r_decode",        0, RT, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("r_execr",         0, RT, 0, 1, 6, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("r_aluwb",         0, RT, 0, 1, 8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    // I-type
    v("i_fetch",         0, IT, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
    v("i_decode",        0, IT, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("i_execi",         0, IT, 0, 1, 7, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("i_aluwb",         0, IT, 0, 1, 8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    // jal
    v("jal_fetch",       0, JL, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 0, 1, 1, 0, 0, 0);
    v("jal_decode",      0, JL, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
    v("jal_jal",         0, JL, 0, 1, 10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0, 1, 0, 0, 0);
    v("jal_aluwb",       0, JL, 0, 1, 8, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 1, 0, 0);
    // illegal opcode
    v("ill_fetch",       0, BAD, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
    v("ill_decode",      0, BAD, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
    // lw with a MEMREAD stall; first vector also checks return to FETCH after illegal
    v("lws_fetch",       0, LW, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
    v("lws_decode",      0, LW, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("lws_memadr",      0, LW, 0, 1, 2, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("lws_memrd_stall", 0, LW, 0, 0, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    v("lws_memread",     0, LW, 0, 1, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    v("lws_memwb",       0, LW, 0, 1, 4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0);
    // reset asserted during MEMWRITE
    v("rsw_fetch",       0, SW, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 0, 1, 1, 0, 0, 0);
    v("rsw_decode",      0, SW, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
    v("rsw_memadr",      0, SW, 0, 1, 2, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
    v("rsw_memwr_rst",   1, SW, 0, 0, 5, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0);
    v("post_rst_fetch",  0, LW, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
    v("post_rst_decode", 0, LW, 0, 1, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("post_rst_memadr", 0, LW, 0, 1, 2, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    v("post_rst_memrd",  0, LW, 0, 1, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    v("post_rst_memwb",  0, LW, 0, 1, 4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0);
    v("post_rst_idle",   0, LW, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
